// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master, one-slave arbiter for pipelined Wishbone.
//   Master 0 is instruction fetch and master 1 is load/store. Both share one slave port.
//   Ownership changes only once the current owner has no un-acked requests in flight.
//   Every ack is routed back to the master that issued the request.
//
// Build option:
//   WB_ARB_ROUND_ROBIN_EN  When defined, simultaneous requests in idle go to the master
//                          opposite the last-grant pointer. When undefined, master 1 wins
//                          simultaneous requests and no pointer is built.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   mX_cyc_i .. mX_wdata_i  master X request signals (cyc, stb, addr, we, lock, sel, wdata)
//   mX_rdata_o              read data broadcast from the slave
//   mX_ack_o, mX_stall_o    per-master ack and stall
//   s_*_o                   owner's request signals, forwarded to the slave
//   s_rdata_i, s_ack_i,
//   s_stall_i               slave responses
//   grant_o                 one-hot owner: bit0 = master 0, bit1 = master 1, 0 = idle
module wb_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic            m0_we_i,
  input  logic            m0_lock_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [DW-1:0]   m0_wdata_i,
  output logic [DW-1:0]   m0_rdata_o,
  output logic            m0_ack_o,
  output logic            m0_stall_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic            m1_we_i,
  input  logic            m1_lock_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [DW-1:0]   m1_wdata_i,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            m1_ack_o,
  output logic            m1_stall_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [AW-1:0]   s_addr_o,
  output logic            s_we_o,
  output logic            s_lock_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [DW-1:0]   s_wdata_o,
  input  logic [DW-1:0]   s_rdata_i,
  input  logic            s_ack_i,
  input  logic            s_stall_i,
  output logic [1:0]      grant_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            own_cyc, own_stb, own_we, own_lock;
  logic [AW-1:0]   own_addr;
  logic [DW/8-1:0] own_sel;
  logic [DW-1:0]   own_wdata;
  logic            at_max, accept, ack_valid, req0, req1;

  // Owner request mux; everything reads as zero while idle.
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_lock  = 1'b0;
    own_addr  = '0;
    own_sel   = '0;
    own_wdata = '0;
    case (state_q)
      StOwn0: begin
        own_cyc   = m0_cyc_i;
        own_stb   = m0_stb_i;
        own_we    = m0_we_i;
        own_lock  = m0_lock_i;
        own_addr  = m0_addr_i;
        own_sel   = m0_sel_i;
        own_wdata = m0_wdata_i;
      end
      StOwn1: begin
        own_cyc   = m1_cyc_i;
        own_stb   = m1_stb_i;
        own_we    = m1_we_i;
        own_lock  = m1_lock_i;
        own_addr  = m1_addr_i;
        own_sel   = m1_sel_i;
        own_wdata = m1_wdata_i;
      end
      default: ;
    endcase
  end

  assign at_max    = (cnt_q == CntMax);
  assign s_cyc_o   = own_cyc;
  assign s_stb_o   = own_stb & ~at_max;
  assign s_addr_o  = own_addr;
  assign s_we_o    = own_we;
  assign s_lock_o  = own_lock;
  assign s_sel_o   = own_sel;
  assign s_wdata_o = own_wdata;

  assign accept    = s_cyc_o & s_stb_o & ~s_stall_i;
  // An ack with nothing outstanding belongs to an aborted or reset cycle: drop it.
  assign ack_valid = s_ack_i & (cnt_q != '0);

  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;
  assign m0_ack_o   = ack_valid & (state_q == StOwn0);
  assign m1_ack_o   = ack_valid & (state_q == StOwn1);
  assign m0_stall_o = (state_q != StOwn0) | s_stall_i | at_max;
  assign m1_stall_o = (state_q != StOwn1) | s_stall_i | at_max;
  assign grant_o    = {state_q == StOwn1, state_q == StOwn0};

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != StIdle) && !own_cyc) begin
      cnt_d = '0;  // owner aborted its cycle
    end else if (accept && !ack_valid) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!accept && ack_valid) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;  // index of the most recently granted master
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req0 && req1) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
          state_d = last_q ? StOwn0 : StOwn1;
`else
          state_d = StOwn1;
`endif
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if ((!m0_stb_i || !m0_cyc_i) && (cnt_d == '0) && !m0_lock_i) begin
          if (req1) begin
            state_d = StOwn1;
          end else if (!m0_cyc_i) begin
            state_d = StIdle;
          end
        end
      end
      StOwn1: begin
        if ((!m1_stb_i || !m1_cyc_i) && (cnt_d == '0) && !m1_lock_i) begin
          if (req0) begin
            state_d = StOwn0;
          end else if (!m1_cyc_i) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if (state_d != state_q) begin
      if (state_d == StOwn0) begin
        last_d = 1'b0;
      end else if (state_d == StOwn1) begin
        last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int MAXO = 4;
`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc, stb, we, lock;
  logic [31:0] addr [2];
  logic [3:0]  sel [2];
  logic [31:0] wdata [2];
  logic [31:0] s_rdata;
  logic        s_ack, s_stall;

  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        m0_ack, m1_ack, m0_stall, m1_stall;
  logic        s_cyc, s_stb, s_we, s_lock;
  logic [3:0]  s_sel;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: owner index (-1 idle), in-flight count, last granted master.
  int mdl_own = -1;
  int mdl_cnt = 0;
  int mdl_last = 1;

  always #5 clk = ~clk;

  wb_arbiter #(.MAX_OUTSTANDING(MAXO), .AW(32), .DW(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_addr_i(addr[0]), .m0_we_i(we[0]),
    .m0_lock_i(lock[0]), .m0_sel_i(sel[0]), .m0_wdata_i(wdata[0]), .m0_rdata_o(m0_rdata),
    .m0_ack_o(m0_ack), .m0_stall_o(m0_stall),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_addr_i(addr[1]), .m1_we_i(we[1]),
    .m1_lock_i(lock[1]), .m1_sel_i(sel[1]), .m1_wdata_i(wdata[1]), .m1_rdata_o(m1_rdata),
    .m1_ack_o(m1_ack), .m1_stall_o(m1_stall),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_addr_o(s_addr), .s_we_o(s_we), .s_lock_o(s_lock),
    .s_sel_o(s_sel), .s_wdata_o(s_wdata), .s_rdata_i(s_rdata), .s_ack_i(s_ack),
    .s_stall_i(s_stall), .grant_o(grant)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cyc = '0; stb = '0; we = '0; lock = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 32'h0; sel[i] = 4'h0; wdata[i] = 32'h0;
    end
    s_ack = 1'b0; s_stall = 1'b0; s_rdata = 32'h0;
  endtask

  // Compare every output with the model, clock once, then advance the model.
  task automatic step();
    logic        e_cyc, e_stb, e_we, e_lock, at_max, acc, dec;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_sel;
    logic [1:0]  e_grant, e_ack, e_stall;
    int          own, ncnt, nown;
    #1;
    own    = mdl_own;
    at_max = (mdl_cnt == MAXO);
    e_cyc = 0; e_stb = 0; e_we = 0; e_lock = 0;
    e_addr = 0; e_wdata = 0; e_sel = 0; e_grant = 0;
    if (own >= 0) begin
      e_cyc   = cyc[own];
      e_stb   = stb[own] && !at_max;
      e_we    = we[own];
      e_lock  = lock[own];
      e_addr  = addr[own];
      e_wdata = wdata[own];
      e_sel   = sel[own];
      e_grant[own] = 1'b1;
    end
    for (int x = 0; x < 2; x++) begin
      e_ack[x]   = s_ack && (own == x) && (mdl_cnt > 0);
      e_stall[x] = (own != x) || s_stall || at_max;
    end
    check("grant", grant, e_grant);
    check("s_cyc", s_cyc, e_cyc);
    check("s_stb", s_stb, e_stb);
    check("s_addr", s_addr, e_addr);
    check("s_we", s_we, e_we);
    check("s_lock", s_lock, e_lock);
    check("s_sel", s_sel, e_sel);
    check("s_wdata", s_wdata, e_wdata);
    check("m0_ack", m0_ack, e_ack[0]);
    check("m1_ack", m1_ack, e_ack[1]);
    check("m0_stall", m0_stall, e_stall[0]);
    check("m1_stall", m1_stall, e_stall[1]);
    check("m0_rdata", m0_rdata, s_rdata);
    check("m1_rdata", m1_rdata, s_rdata);
    @(posedge clk);
    if (rst) begin
      mdl_own = -1; mdl_cnt = 0; mdl_last = 1;
    end else begin
      acc = e_cyc && e_stb && !s_stall;
      dec = s_ack && (mdl_cnt > 0);
      if (own >= 0 && !cyc[own]) ncnt = 0;
      else ncnt = mdl_cnt + int'(acc) - int'(dec);
      nown = own;
      if (own < 0) begin
        if (cyc[0] && stb[0] && cyc[1] && stb[1]) nown = RR ? 1 - mdl_last : 1;
        else if (cyc[0] && stb[0]) nown = 0;
        else if (cyc[1] && stb[1]) nown = 1;
      end else if ((!stb[own] || !cyc[own]) && ncnt == 0 && !lock[own]) begin
        if (cyc[1-own] && stb[1-own]) nown = 1 - own;
        else if (!cyc[own]) nown = -1;
      end
      if (nown >= 0 && nown != own) mdl_last = nown;
      mdl_own = nown;
      mdl_cnt = ncnt;
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    rst = 1'b0;
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_s_stb", s_stb, 1'b0);
    check("rst_m0_ack", m0_ack, 1'b0);
    check("rst_m1_ack", m1_ack, 1'b0);
    check("rst_m0_stall", m0_stall, 1'b1);
    check("rst_m1_stall", m1_stall, 1'b1);
    step();

    // Single m0 read: grant one cycle after request, ack routed to m0 only
    cyc[0] = 1; stb[0] = 1; addr[0] = 32'h8000_0000;
    #1;
    check("t1_req_grant", grant, 2'b00);
    check("t1_req_stall", m0_stall, 1'b1);
    step();
    check("t1_grant", grant, 2'b01);
    check("t1_s_addr", s_addr, 32'h8000_0000);
    check("t1_s_stb", s_stb, 1'b1);
    step();
    stb[0] = 0; s_ack = 1; s_rdata = 32'hDEAD_BEEF;
    #1;
    check("t1_m0_ack", m0_ack, 1'b1);
    check("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("t1_m1_ack", m1_ack, 1'b0);
    step();
    idle_inputs();
    step();

    // Outstanding limit: 4 un-acked requests, then one ack frees a slot
    cyc[0] = 1; stb[0] = 1; addr[0] = 32'h0000_1000;
    step();
    for (int i = 0; i < MAXO; i++) step();
    #1;
    check("t2_full_stall", m0_stall, 1'b1);
    check("t2_full_stb", s_stb, 1'b0);
    step();
    s_ack = 1;
    step();
    s_ack = 0;
    #1;
    check("t2_slot_stb", s_stb, 1'b1);
    check("t2_slot_stall", m0_stall, 1'b0);
    step();
    idle_inputs();
    step();

    // Handover waits for m0 to drain its two outstanding requests
    cyc[0] = 1; stb[0] = 1;
    step();
    step();
    step();
    stb[0] = 0; cyc[1] = 1; stb[1] = 1; addr[1] = 32'h0000_2000;
    #1;
    check("t3_m1_stall_a", m1_stall, 1'b1);
    step();
    s_ack = 1;
    #1;
    check("t3_grant_b", grant, 2'b01);
    check("t3_m1_stall_b", m1_stall, 1'b1);
    step();
    #1;
    check("t3_grant_c", grant, 2'b01);
    check("t3_m1_stall_c", m1_stall, 1'b1);
    step();
    s_ack = 0;
    #1;
    check("t3_grant_m1", grant, 2'b10);
    check("t3_m1_stall_d", m1_stall, 1'b0);

    // Lock held by m1 keeps the bus despite m0 requesting
    stb[1] = 0; lock[1] = 1; cyc[0] = 1; stb[0] = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_locked_grant", grant, 2'b10);
      step();
    end
    lock[1] = 0;
    #1;
    check("t4_unlock_grant", grant, 2'b10);
    step();
    #1;
    check("t4_handover_grant", grant, 2'b01);
    idle_inputs();
    step();

    // Simultaneous requests from idle; last grant so far went to m0
    for (int r = 0; r < 6; r++) begin
      logic [1:0] exp_g;
      if (RR) exp_g = (r % 2 == 0) ? 2'b10 : 2'b01;
      else exp_g = 2'b10;
      cyc = 2'b11; stb = 2'b11;
      step();
      #1;
      check("t5_both_grant", grant, exp_g);
      idle_inputs();
      s_ack = 1;
      step();
      s_ack = 0;
    end
    step();

    // Reset with three requests in flight; late ack must not reach m0
    cyc[0] = 1; stb[0] = 1;
    step();
    for (int i = 0; i < 3; i++) step();
    stb[0] = 0; rst = 1;
    step();
    rst = 0; cyc[0] = 0; s_ack = 1;
    #1;
    check("t6_grant", grant, 2'b00);
    check("t6_m0_ack", m0_ack, 1'b0);
    check("t6_m0_stall", m0_stall, 1'b1);
    step();
    idle_inputs();
    // Counter restarted from zero: exactly MAXO accepts before stalling
    cyc[0] = 1; stb[0] = 1;
    step();
    for (int i = 0; i < MAXO; i++) begin
      #1;
      check("t6_fill_stall", m0_stall, 1'b0);
      step();
    end
    #1;
    check("t6_full_stall", m0_stall, 1'b1);
    idle_inputs();
    step();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        cyc[i]   = ($urandom_range(0, 7) != 0);
        stb[i]   = $urandom_range(0, 1) != 0;
        we[i]    = $urandom_range(0, 1) != 0;
        lock[i]  = ($urandom_range(0, 15) == 0);
        addr[i]  = $urandom;
        sel[i]   = 4'($urandom);
        wdata[i] = $urandom;
      end
      s_ack   = ($urandom_range(0, 2) == 0);
      s_stall = ($urandom_range(0, 3) == 0);
      s_rdata = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master, one-slave arbiter for the pipelined Wishbone bus. It lets the instruction fetch unit (master 0) and the load/store unit (master 1) share a single memory port. The arbiter tracks outstanding acknowledges so that ownership changes only when the bus has drained, and it routes every `ack` back to the master that issued the request. It sits between the core's fetch and LSU `wishbone_if` ports and the memory or interconnect.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum number of un-acked requests the current owner may have in flight; range 1..7.
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: synchronous, active-high reset.
- `m0_if`, `wishbone_if.SLAVE`: fetch master. Signals are cyc, stb, addr, we, lock, sel, wdata, rdata, ack, stall.
- `m1_if`, `wishbone_if.SLAVE`: LSU master, same signals.
- `s_if`, `wishbone_if.MASTER`: shared slave port.
- `grant_o`, output, 2: one-hot owner; `2'b00` means idle. Debug/perf use only.

## Operation
- FSM states: IDLE, OWN0, OWN1. Ownership is registered.
- The owner's cyc, stb, addr, we, lock, sel and wdata are driven to `s_if`.
- In IDLE, `s_if.cyc` and `s_if.stb` are 0; other `s_if` outputs are 0.
- `s_if.rdata` is broadcast to both masters.
- `mX.ack = s_if.ack & (owner==X)`.
- `mX.stall = 1` when X is not the owner.
- For the owner, `stall = s_if.stall | (cnt == MAX_OUTSTANDING)`.
- `s_if.stb = owner.stb & !(cnt == MAX_OUTSTANDING)`.
- Outstanding counter `cnt`, width `$clog2(MAX_OUTSTANDING+1)`:
  - +1 on an accepted request (`s_if.cyc & s_if.stb & !s_if.stall`).
  - −1 on `s_if.ack`.
  - Both in the same cycle: unchanged.
  - An ack while `cnt==0` is ignored (counter stays 0).
- Request of master X: `req_X = mX.cyc & mX.stb`.
- IDLE → OWNx when `req_x` is seen. Both requesting: priority per Configuration.
- OWNx release condition, all required in the same cycle:
  - `!mX.stb` or `!mX.cyc`;
  - `cnt_d == 0`;
  - `!mX.lock`.
- On release:
  - go to OWNy if `req_y`;
  - else go to IDLE if `!mX.cyc`;
  - else stay in OWNx.
- A master that holds cyc with stb low (e.g. fetch waiting on a CPU stall) therefore keeps the bus only until the other master requests.
- Owner drops cyc with `cnt != 0` (abort):
  - `cnt` is cleared;
  - next state follows the release rule;
  - any late slave acks are blocked (owner check plus `cnt==0`).
- `lock` held by the owner blocks release regardless of other requests.

## Timing
- Reset values: state IDLE, `cnt=0`, `grant_o=0`, `s_if.cyc=s_if.stb=0`, `m0/m1.ack=0`, `m0/m1.stall=1`, last-grant pointer = master 1.
- Arbitration latency is 1 cycle. A request first seen at cycle N is visible on `s_if` at N+1; the master sees `stall=1` at cycle N.
- Handover latency:
  - release detected at N;
  - new owner drives `s_if` at N+1;
  - there is no cycle in which both masters are connected.
- `ack` and `rdata` pass combinationally from `s_if` to the owner; no added latency.
- Back-to-back requests from the owner proceed at 1 per cycle until `cnt == MAX_OUTSTANDING`.
- Reset asserted mid-transaction: all state returns to reset values on the next edge; in-flight acks are dropped.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN` defined:
  - simultaneous requests in IDLE grant the master opposite to the last-grant pointer;
  - the pointer updates on every grant.
- `WB_ARB_ROUND_ROBIN_EN` undefined:
  - fixed priority, master 1 (LSU) wins simultaneous requests;
  - the pointer is not implemented.
- Handover rules in OWNx are identical in both builds.

## Test plan
- Reset, then m0 requests addr `0x8000_0000`:
  - `grant_o=01` and `s_if.addr=0x8000_0000` one cycle later;
  - m0 receives `ack` plus rdata; m1 `ack` stays 0.
- m0 issues 4 back-to-back requests with the slave never acking (`MAX_OUTSTANDING=4`):
  - `m0.stall=1` after the 4th;
  - 5th stb not forwarded;
  - one ack → next request accepted.
- m0 owns with 2 outstanding, drops stb, and m1 requests:
  - grant moves to m1 only the cycle after the 2nd ack;
  - m1 stall=1 until then.
- m1 owns with `lock=1`, stb low, `cnt=0`, m0 requesting: grant stays `10` until lock drops, then `01` next cycle.
- Both request in IDLE repeatedly, each releasing after 1 transfer:
  - grants alternate m0/m1 with `WB_ARB_ROUND_ROBIN_EN`;
  - m1 always first without it.
- `rst_i` asserted while m0 has 3 outstanding:
  - next cycle `grant_o=00`, `cnt=0`;
  - a slave ack arriving afterward produces no master ack.
